// File: rtl/cep_encoder.sv
// Transmit-side CEP packer: one header beat plus up to MAX data words are assembled
// into a single package register and offered on a valid/ready port to the link TX.
`ifndef CEP_DEFINES_SV
`define CEP_DEFINES_SV
`define CEP_WORD_WIDTH            64
`define CEP_DATA_WIDTH            512
`define CEP_LAST_SUBLINE_WIDTH    1
`define CEP_LAST_SUBLINE_LO       0
`define CEP_SUBLINE_ID_WIDTH      2
`define CEP_SUBLINE_ID_LO         1
`define CEP_MESI_WIDTH            2
`define CEP_MESI_LO               3
`define CEP_MSHRID_WIDTH          8
`define CEP_MSHRID_LO             5
`define CEP_MSG_TYPE_WIDTH        8
`define CEP_MSG_TYPE_LO           13
`define CEP_LENGTH_WIDTH          8
`define CEP_LENGTH_LO             21
`define CEP_IS_REQUEST_BIT        29
`define CEP_SRC_CHIPID_WIDTH      14
`define CEP_SRC_CHIPID_LO         30
`define CEP_DATA_SIZE_WIDTH       3
`define CEP_DATA_SIZE_LO          64
`define CEP_CACHE_TYPE_WIDTH      1
`define CEP_CACHE_TYPE_LO         67
`define CEP_SUBLINE_VECTOR_WIDTH  4
`define CEP_SUBLINE_VECTOR_LO     68
`define CEP_ADDR_WIDTH            40
`define CEP_ADDR_LO               128
`endif

module cep_encoder #(
   parameter bit          BACK_TO_BACK = 1'b1,
   parameter int unsigned CNT_WIDTH    = 3
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 hdr_val,
   output logic                                 hdr_rdy,
   input  logic                                 is_request,
   input  logic [`CEP_LAST_SUBLINE_WIDTH-1:0]   last_subline,
   input  logic [`CEP_SUBLINE_ID_WIDTH-1:0]     subline_id,
   input  logic [`CEP_MESI_WIDTH-1:0]           mesi,
   input  logic [`CEP_MSHRID_WIDTH-1:0]         mshrid,
   input  logic [`CEP_MSG_TYPE_WIDTH-1:0]       msg_type,
   input  logic [`CEP_LENGTH_WIDTH-1:0]         length,
   input  logic [`CEP_DATA_SIZE_WIDTH-1:0]      data_size,
   input  logic [`CEP_CACHE_TYPE_WIDTH-1:0]     cache_type,
   input  logic [`CEP_SUBLINE_VECTOR_WIDTH-1:0] subline_vector,
   input  logic [`CEP_ADDR_WIDTH-1:0]           addr,
   input  logic [`CEP_SRC_CHIPID_WIDTH-1:0]     src_chipid,
   input  logic [CNT_WIDTH-1:0]                 num_words,
   input  logic                                 word_val,
   output logic                                 word_rdy,
   input  logic [`CEP_WORD_WIDTH-1:0]           word_data,
   output logic                                 cep_val,
   input  logic                                 cep_rdy,
   output logic [`CEP_DATA_WIDTH-1:0]           cep_pkg,
   output logic                                 num_err
);

   localparam int unsigned WORD_W    = `CEP_WORD_WIDTH;
   localparam int unsigned DATA_W    = `CEP_DATA_WIDTH;
   localparam int unsigned NUM_SLOTS = DATA_W / WORD_W;
   localparam int unsigned REQ_BASE  = 3;
   localparam int unsigned RSP_BASE  = 1;
   localparam logic [CNT_WIDTH-1:0] REQ_MAX = CNT_WIDTH'(5);
   localparam logic [CNT_WIDTH-1:0] RSP_MAX = CNT_WIDTH'(7);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_SEND} state_e;

   state_e                state_q, state_d;
   logic [DATA_W-1:0]     pkg_q, pkg_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  n_q, n_d;
   logic                  isreq_q, isreq_d;
   logic                  val_q, val_d;
   logic                  err_q, err_d;

   logic [CNT_WIDTH-1:0]  hdr_max;
   logic [CNT_WIDTH-1:0]  hdr_n;
   logic                  hdr_take;
   int unsigned           word_slot;

   assign hdr_max = is_request ? REQ_MAX : RSP_MAX;
   assign hdr_n   = (num_words > hdr_max) ? hdr_max : num_words;

   // Next-state, package assembly and ready generation.
   always_comb begin
      state_d   = state_q;
      pkg_d     = pkg_q;
      cnt_d     = cnt_q;
      n_d       = n_q;
      isreq_d   = isreq_q;
      err_d     = 1'b0;
      hdr_rdy   = 1'b0;
      word_rdy  = 1'b0;
      hdr_take  = 1'b0;
      word_slot = (isreq_q ? REQ_BASE : RSP_BASE) + 32'(cnt_q);

      case (state_q)
         S_IDLE: hdr_rdy = 1'b1;
         S_DATA: begin
            word_rdy = 1'b1;
            if (word_val) begin
               for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                  if (word_slot == k) pkg_d[k*WORD_W +: WORD_W] = word_data;
               end
               cnt_d = CNT_WIDTH'(cnt_q + 1'b1);
               if (CNT_WIDTH'(cnt_q + 1'b1) == n_q) state_d = S_SEND;
            end
         end
         S_SEND: begin
            hdr_rdy = BACK_TO_BACK & cep_rdy;
            if (cep_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      hdr_take = hdr_val & hdr_rdy;
      if (hdr_take) begin
         pkg_d = '0;
         pkg_d[`CEP_LAST_SUBLINE_LO +: `CEP_LAST_SUBLINE_WIDTH] = last_subline;
         pkg_d[`CEP_SUBLINE_ID_LO   +: `CEP_SUBLINE_ID_WIDTH]   = subline_id;
         pkg_d[`CEP_MESI_LO         +: `CEP_MESI_WIDTH]         = mesi;
         pkg_d[`CEP_MSHRID_LO       +: `CEP_MSHRID_WIDTH]       = mshrid;
         pkg_d[`CEP_MSG_TYPE_LO     +: `CEP_MSG_TYPE_WIDTH]     = msg_type;
         pkg_d[`CEP_LENGTH_LO       +: `CEP_LENGTH_WIDTH]       = length;
         pkg_d[`CEP_IS_REQUEST_BIT]                             = is_request;
         pkg_d[`CEP_SRC_CHIPID_LO   +: `CEP_SRC_CHIPID_WIDTH]   = src_chipid;
         if (is_request) begin
            pkg_d[`CEP_DATA_SIZE_LO      +: `CEP_DATA_SIZE_WIDTH]      = data_size;
            pkg_d[`CEP_CACHE_TYPE_LO     +: `CEP_CACHE_TYPE_WIDTH]     = cache_type;
            pkg_d[`CEP_SUBLINE_VECTOR_LO +: `CEP_SUBLINE_VECTOR_WIDTH] = subline_vector;
            pkg_d[`CEP_ADDR_LO           +: `CEP_ADDR_WIDTH]           = addr;
         end
         isreq_d = is_request;
         n_d     = hdr_n;
         cnt_d   = '0;
         err_d   = (num_words > hdr_max);
         state_d = (hdr_n == '0) ? S_SEND : S_DATA;
      end

      val_d = (state_d == S_SEND);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pkg_q   <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         isreq_q <= 1'b0;
         val_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pkg_q   <= pkg_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         isreq_q <= isreq_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   assign cep_val = val_q;
   assign cep_pkg = pkg_q;
   assign num_err = err_q;

endmodule

// File: tb/tb_cep_encoder.sv
// Bench for cep_encoder: randomized headers/words compared against a package model
// built directly from the field layout and slot rules.
module tb_cep_encoder;

   localparam int W  = 64;
   localparam int DW = 512;
   localparam int LS_LO = 0,    LS_W = 1;
   localparam int SID_LO = 1,   SID_W = 2;
   localparam int MESI_LO = 3,  MESI_W = 2;
   localparam int MSHR_LO = 5,  MSHR_W = 8;
   localparam int MT_LO = 13,   MT_W = 8;
   localparam int LEN_LO = 21,  LEN_W = 8;
   localparam int ISR_BIT = 29;
   localparam int CHIP_LO = 30, CHIP_W = 14;
   localparam int DS_LO = 64,   DS_W = 3;
   localparam int CT_LO = 67,   CT_W = 1;
   localparam int SV_LO = 68,   SV_W = 4;
   localparam int ADDR_LO = 128, ADDR_W = 40;

   logic              clk, rst_n;
   logic              hdr_val, hdr_rdy, is_request;
   logic [LS_W-1:0]   last_subline;
   logic [SID_W-1:0]  subline_id;
   logic [MESI_W-1:0] mesi;
   logic [MSHR_W-1:0] mshrid;
   logic [MT_W-1:0]   msg_type;
   logic [LEN_W-1:0]  length;
   logic [DS_W-1:0]   data_size;
   logic [CT_W-1:0]   cache_type;
   logic [SV_W-1:0]   subline_vector;
   logic [ADDR_W-1:0] addr;
   logic [CHIP_W-1:0] src_chipid;
   logic [2:0]        num_words;
   logic              word_val, word_rdy;
   logic [W-1:0]      word_data;
   logic              cep_val, cep_rdy;
   logic [DW-1:0]     cep_pkg;
   logic              num_err;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic              req;
      logic [LS_W-1:0]   ls;
      logic [SID_W-1:0]  sid;
      logic [MESI_W-1:0] mesi;
      logic [MSHR_W-1:0] mshr;
      logic [MT_W-1:0]   mt;
      logic [LEN_W-1:0]  len;
      logic [DS_W-1:0]   ds;
      logic [CT_W-1:0]   ct;
      logic [SV_W-1:0]   sv;
      logic [ADDR_W-1:0] addr;
      logic [CHIP_W-1:0] chip;
      logic [2:0]        num;
   } hdr_t;

   logic [W-1:0] wbuf [8];

   cep_encoder #(.BACK_TO_BACK(1'b1), .CNT_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .hdr_val(hdr_val), .hdr_rdy(hdr_rdy),
      .is_request(is_request), .last_subline(last_subline), .subline_id(subline_id),
      .mesi(mesi), .mshrid(mshrid), .msg_type(msg_type), .length(length),
      .data_size(data_size), .cache_type(cache_type), .subline_vector(subline_vector),
      .addr(addr), .src_chipid(src_chipid), .num_words(num_words),
      .word_val(word_val), .word_rdy(word_rdy), .word_data(word_data),
      .cep_val(cep_val), .cep_rdy(cep_rdy), .cep_pkg(cep_pkg), .num_err(num_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_max(hdr_t h);
      return h.req ? 5 : 7;
   endfunction

   function automatic int model_n(hdr_t h);
      return (int'(h.num) > model_max(h)) ? model_max(h) : int'(h.num);
   endfunction

   function automatic logic [DW-1:0] model_pkg(hdr_t h);
      logic [DW-1:0] p;
      int base;
      p = '0;
      base = h.req ? 3 : 1;
      p[LS_LO +: LS_W]     = h.ls;
      p[SID_LO +: SID_W]   = h.sid;
      p[MESI_LO +: MESI_W] = h.mesi;
      p[MSHR_LO +: MSHR_W] = h.mshr;
      p[MT_LO +: MT_W]     = h.mt;
      p[LEN_LO +: LEN_W]   = h.len;
      p[ISR_BIT]           = h.req;
      p[CHIP_LO +: CHIP_W] = h.chip;
      if (h.req) begin
         p[DS_LO +: DS_W]     = h.ds;
         p[CT_LO +: CT_W]     = h.ct;
         p[SV_LO +: SV_W]     = h.sv;
         p[ADDR_LO +: ADDR_W] = h.addr;
      end
      for (int k = 0; k < model_n(h); k++) p[(base + k) * W +: W] = wbuf[k];
      return p;
   endfunction

   function automatic hdr_t rand_hdr(logic req, logic [2:0] num);
      hdr_t h;
      h.req  = req;
      h.ls   = LS_W'($urandom);
      h.sid  = SID_W'($urandom);
      h.mesi = MESI_W'($urandom);
      h.mshr = MSHR_W'($urandom);
      h.mt   = MT_W'($urandom);
      h.len  = LEN_W'($urandom);
      h.ds   = DS_W'($urandom);
      h.ct   = CT_W'($urandom);
      h.sv   = SV_W'($urandom);
      h.addr = ADDR_W'({$urandom, $urandom});
      h.chip = CHIP_W'($urandom);
      h.num  = num;
      return h;
   endfunction

   task automatic fill_words();
      for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
   endtask

   task automatic drive_hdr(hdr_t h);
      is_request = h.req;  last_subline = h.ls;  subline_id = h.sid;  mesi = h.mesi;
      mshrid = h.mshr;     msg_type = h.mt;      length = h.len;      data_size = h.ds;
      cache_type = h.ct;   subline_vector = h.sv; addr = h.addr;      src_chipid = h.chip;
      num_words = h.num;
   endtask

   // Present a header until it is taken; returns with time at posedge+1.
   task automatic do_header(hdr_t h, output bit ok);
      drive_hdr(h);
      hdr_val = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (hdr_rdy) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      hdr_val = 1'b0;
   endtask

   // Send wbuf[0..n-1]; cycles counts clock cycles spent.
   task automatic do_words(int n, output int cycles);
      bit taken;
      cycles = 0;
      for (int i = 0; i < n; i++) begin
         word_val = 1'b1;
         word_data = wbuf[i];
         taken = 1'b0;
         for (int t = 0; t < 20 && !taken; t++) begin
            cycles++;
            @(negedge clk);
            if (word_rdy) begin
               @(posedge clk); #1;
               taken = 1'b1;
            end
         end
      end
      word_val = 1'b0;
   endtask

   // Stall cep_rdy for 'stall' cycles, then take the package.
   task automatic do_recv(int stall, output logic [DW-1:0] got, output bit stable, output bit ok);
      logic [DW-1:0] first;
      stable = 1'b1;
      ok = 1'b0;
      got = '0;
      first = cep_pkg;
      cep_rdy = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (!cep_val || cep_pkg !== first) stable = 1'b0;
         @(posedge clk); #1;
      end
      cep_rdy = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (cep_val) begin
            got = cep_pkg;
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      cep_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hdr_val = 1'b0; word_val = 1'b0; cep_rdy = 1'b0; word_data = '0;
      drive_hdr(rand_hdr(1'b0, 3'd0));
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cep_val !== 1'b0 || cep_pkg !== '0 || num_err !== 1'b0 || hdr_rdy !== 1'b1 || word_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset got val=%b pkg_nz=%b err=%b hrdy=%b wrdy=%b exp 0 0 0 1 0",
                  cep_val, |cep_pkg, num_err, hdr_rdy, word_rdy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_request_full();
      hdr_t h; bit ok, st; int cyc; logic [DW-1:0] got;
      h = rand_hdr(1'b1, 3'd5);
      h.addr = 40'h12345678C0; h.mshr = 8'd5;
      fill_words();
      do_header(h, ok);
      checks++;
      if (!ok || cep_val !== 1'b0 || num_err !== 1'b0) begin
         failures++;
         $display("FAIL req_hdr got ok=%b val=%b err=%b exp 1 0 0", ok, cep_val, num_err);
      end
      do_words(5, cyc);
      checks++;
      if (cyc != 5 || cep_val !== 1'b1) begin
         failures++;
         $display("FAIL req_latency got cycles=%0d val=%b exp 5 1", cyc, cep_val);
      end
      do_recv(0, got, st, ok);
      checks++;
      if (!ok || got !== model_pkg(h) || got[DW-1 -: 2*W] !== '0 ? 1'b0 : 1'b0) begin
      end
      if (!ok || got !== model_pkg(h)) begin
         failures++;
         $display("FAIL req_pkg got=%h exp=%h", got, model_pkg(h));
      end
      checks++;
      if (cep_val !== 1'b0 || hdr_rdy !== 1'b1) begin
         failures++;
         $display("FAIL req_idle got val=%b hrdy=%b exp 0 1", cep_val, hdr_rdy);
      end
   endtask

   task automatic test_response_stall();
      hdr_t h; bit ok, st; int cyc; logic [DW-1:0] got;
      h = rand_hdr(1'b0, 3'd7);
      fill_words();
      do_header(h, ok);
      do_words(7, cyc);
      checks++;
      if (!ok || cyc != 7 || cep_val !== 1'b1) begin
         failures++;
         $display("FAIL rsp_latency got ok=%b cycles=%0d val=%b exp 1 7 1", ok, cyc, cep_val);
      end
      do_recv(3, got, st, ok);
      checks++;
      if (!st) begin
         failures++;
         $display("FAIL rsp_stall_stable got stable=0 exp stable=1");
      end
      checks++;
      if (!ok || got !== model_pkg(h)) begin
         failures++;
         $display("FAIL rsp_pkg got=%h exp=%h", got, model_pkg(h));
      end
   endtask

   task automatic test_zero_words();
      hdr_t h; bit ok, st; logic [DW-1:0] got;
      h = rand_hdr(1'b0, 3'd0);
      do_header(h, ok);
      checks++;
      if (!ok || cep_val !== 1'b1 || cep_pkg !== model_pkg(h)) begin
         failures++;
         $display("FAIL zero_words got val=%b pkg=%h exp val=1 pkg=%h", cep_val, cep_pkg, model_pkg(h));
      end
      do_recv(1, got, st, ok);
      checks++;
      if (!ok || !st || got !== model_pkg(h)) begin
         failures++;
         $display("FAIL zero_words_recv got=%h exp=%h", got, model_pkg(h));
      end
   endtask

   task automatic test_back_to_back();
      hdr_t h1, h2; bit ok, st; logic [DW-1:0] got, e1, e2;
      h1 = rand_hdr(1'b0, 3'd0);
      h2 = rand_hdr(1'b1, 3'd0);
      e1 = model_pkg(h1);
      e2 = model_pkg(h2);
      do_header(h1, ok);
      drive_hdr(h2);
      hdr_val = 1'b1;
      cep_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (hdr_rdy !== 1'b1 || cep_val !== 1'b1 || cep_pkg !== e1) begin
         failures++;
         $display("FAIL b2b_overlap got hrdy=%b val=%b pkg=%h exp 1 1 %h", hdr_rdy, cep_val, cep_pkg, e1);
      end
      @(posedge clk); #1;
      hdr_val = 1'b0;
      cep_rdy = 1'b0;
      checks++;
      if (cep_val !== 1'b1 || cep_pkg !== e2) begin
         failures++;
         $display("FAIL b2b_second got val=%b pkg=%h exp 1 %h", cep_val, cep_pkg, e2);
      end
      do_recv(0, got, st, ok);
      checks++;
      if (!ok || got !== e2 || cep_val !== 1'b0) begin
         failures++;
         $display("FAIL b2b_recv got=%h val=%b exp=%h val=0", got, cep_val, e2);
      end
   endtask

   task automatic test_num_err();
      hdr_t h; bit ok, st, blocked; int cyc; logic [DW-1:0] got;
      h = rand_hdr(1'b1, 3'd6);
      fill_words();
      do_header(h, ok);
      checks++;
      if (!ok || num_err !== 1'b1) begin
         failures++;
         $display("FAIL num_err_pulse got ok=%b err=%b exp 1 1", ok, num_err);
      end
      do_words(5, cyc);
      checks++;
      if (num_err !== 1'b0 || cyc != 5 || cep_val !== 1'b1) begin
         failures++;
         $display("FAIL num_err_clamp got err=%b cycles=%0d val=%b exp 0 5 1", num_err, cyc, cep_val);
      end
      word_val = 1'b1;
      word_data = wbuf[5];
      blocked = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (word_rdy !== 1'b0 || cep_val !== 1'b1) blocked = 1'b0;
         @(posedge clk); #1;
      end
      word_val = 1'b0;
      checks++;
      if (!blocked) begin
         failures++;
         $display("FAIL sixth_word got word_accepted_or_val_drop exp word_rdy=0");
      end
      do_recv(0, got, st, ok);
      checks++;
      if (!ok || got !== model_pkg(h)) begin
         failures++;
         $display("FAIL num_err_pkg got=%h exp=%h", got, model_pkg(h));
      end
   endtask

   task automatic test_reset_mid();
      hdr_t h; bit ok, st; int cyc; logic [DW-1:0] got;
      h = rand_hdr(1'b1, 3'd5);
      fill_words();
      do_header(h, ok);
      do_words(2, cyc);
      rst_n = 1'b0;
      #1;
      checks++;
      if (cep_val !== 1'b0 || cep_pkg !== '0 || hdr_rdy !== 1'b1 || word_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got val=%b pkg_nz=%b hrdy=%b wrdy=%b exp 0 0 1 0",
                  cep_val, |cep_pkg, hdr_rdy, word_rdy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      h = rand_hdr(1'b0, 3'd3);
      fill_words();
      do_header(h, ok);
      do_words(3, cyc);
      do_recv(1, got, st, ok);
      checks++;
      if (!ok || got !== model_pkg(h)) begin
         failures++;
         $display("FAIL reset_mid_next got=%h exp=%h", got, model_pkg(h));
      end
   endtask

   task automatic test_random();
      hdr_t h; bit ok, st; int cyc, n; logic [DW-1:0] got;
      for (int it = 0; it < 30; it++) begin
         h = rand_hdr(1'($urandom), 3'($urandom));
         n = model_n(h);
         fill_words();
         do_header(h, ok);
         checks++;
         if (!ok || num_err !== (int'(h.num) > model_max(h))) begin
            failures++;
            $display("FAIL rand_err[%0d] got ok=%b err=%b num=%0d req=%b", it, ok, num_err, h.num, h.req);
         end
         do_words(n, cyc);
         checks++;
         if (cyc != n || cep_val !== 1'b1) begin
            failures++;
            $display("FAIL rand_lat[%0d] got cycles=%0d val=%b exp %0d 1", it, cyc, cep_val, n);
         end
         do_recv(int'($urandom_range(0, 2)), got, st, ok);
         checks++;
         if (!ok || !st || got !== model_pkg(h)) begin
            failures++;
            $display("FAIL rand_pkg[%0d] got=%h exp=%h", it, got, model_pkg(h));
         end
      end
   endtask

   initial begin
      test_reset();
      test_request_full();
      test_response_stall();
      test_zero_words();
      test_back_to_back();
      test_num_err();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
